// File: rtl/sw_pkg.sv
// Shared types and constants for the stopwatch controller: FSM states,
// datapath digit widths and the 59:59 preset value.
package sw_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } sw_state_e;

    localparam int MIN_ONES_W = 4;
    localparam int MIN_TENS_W = 3;
    localparam int SEC_ONES_W = 4;
    localparam int SEC_TENS_W = 3;

    localparam int PRESET_M1 = 5;
    localparam int PRESET_M2 = 9;
    localparam int PRESET_S1 = 5;
    localparam int PRESET_S2 = 9;

    typedef struct packed {
        logic [MIN_ONES_W-1:0] m2;
        logic [MIN_TENS_W-1:0] m1;
        logic [SEC_ONES_W-1:0] s2;
        logic [SEC_TENS_W-1:0] s1;
    } digits_t;

endpackage

// File: rtl/stop_watch_ctrl_if.sv
// Button, datapath and display bundle of the stopwatch controller.
// The controller is the master; the datapath/display side is the slave.
interface stop_watch_ctrl_if;
    import sw_pkg::*;

    logic                  start_stop;
    logic                  lap;
    logic                  clear;
    logic [MIN_ONES_W-1:0] cnt_m2;
    logic [MIN_TENS_W-1:0] cnt_m1;
    logic [SEC_ONES_W-1:0] cnt_s2;
    logic [SEC_TENS_W-1:0] cnt_s1;
    logic                  cnt_en;
    logic                  cnt_load;
    logic [MIN_ONES_W-1:0] disp_m2;
    logic [MIN_TENS_W-1:0] disp_m1;
    logic [SEC_ONES_W-1:0] disp_s2;
    logic [SEC_TENS_W-1:0] disp_s1;
    logic                  running;
    logic                  paused;
    logic                  expired;
    logic                  lap_active;

    modport master (
        input  start_stop, lap, clear, cnt_m2, cnt_m1, cnt_s2, cnt_s1,
        output cnt_en, cnt_load, disp_m2, disp_m1, disp_s2, disp_s1,
        output running, paused, expired, lap_active
    );

    modport slave (
        output start_stop, lap, clear, cnt_m2, cnt_m1, cnt_s2, cnt_s1,
        input  cnt_en, cnt_load, disp_m2, disp_m1, disp_s2, disp_s1,
        input  running, paused, expired, lap_active
    );

endinterface

// File: rtl/sw_prescaler.sv
// One-second prescaler: counts only while run is high, holds otherwise so a
// resumed second keeps its partial progress; clr forces it back to zero.
module sw_prescaler #(
    parameter int TICK_DIV = 50_000_000,
    parameter int PS_W     = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam logic [PS_W-1:0] LAST = PS_W'(TICK_DIV - 1);

    logic [PS_W-1:0] ps_reg;
    logic [PS_W-1:0] ps_next;

    always_comb begin
        ps_next = ps_reg;
        if (clr) begin
            ps_next = '0;
        end else if (run) begin
            ps_next = (ps_reg == LAST) ? '0 : ps_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ps_reg <= '0;
        end else begin
            ps_reg <= ps_next;
        end
    end

    assign tick = run && (ps_reg == LAST);

endmodule

// File: rtl/stop_watch_ctrl.sv
// Run/pause/lap/clear sequencer for the mm:ss countdown datapath: turns
// debounced button levels into decrement/preset strobes and a lap-hold display.
module stop_watch_ctrl
    import sw_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int PS_W     = 26
) (
    input  logic              clk,
    input  logic              reset,
    stop_watch_ctrl_if.master bus
);

    localparam int NBTN = 3;

    sw_state_e       state_reg;
    sw_state_e       state_next;
    logic [NBTN-1:0] btn;
    logic [NBTN-1:0] btn_prev_reg;
    logic [NBTN-1:0] btn_ev;
    logic            ss_ev;
    logic            lap_ev;
    logic            clr_ev;
    logic            zero;
    logic            tick;
    logic            exp_entry;
    logic            lap_take;
    logic            cnt_en_reg;
    logic            cnt_load_reg;
    logic            lap_active_reg;
    digits_t         live;
    digits_t         hold_reg;
    digits_t         disp_sel;

    // Bit order fixes event priority lookups: 0 start_stop, 1 lap, 2 clear.
    assign btn = {bus.clear, bus.lap, bus.start_stop};

    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_prev_reg <= '0;
        end else begin
            btn_prev_reg <= btn;
        end
    end

    for (genvar gi = 0; gi < NBTN; gi++) begin : g_edge
        assign btn_ev[gi] = btn[gi] & ~btn_prev_reg[gi];
    end

    assign ss_ev  = btn_ev[0];
    assign lap_ev = btn_ev[1];
    assign clr_ev = btn_ev[2];

    assign live = {bus.cnt_m2, bus.cnt_m1, bus.cnt_s2, bus.cnt_s1};
    assign zero = (live == '0);

    assign exp_entry = (state_reg == RUN) && zero && !clr_ev;
    // Lap loses to clear, start_stop and expiry arriving in the same cycle.
    assign lap_take  = lap_ev && !ss_ev && !clr_ev && !exp_entry &&
                       ((state_reg == RUN) || (state_reg == PAUSE));

    sw_prescaler #(
        .TICK_DIV (TICK_DIV),
        .PS_W     (PS_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (state_reg == RUN),
        .clr   (clr_ev | exp_entry),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (clr_ev) begin
            state_next = IDLE;
        end else begin
            unique case (state_reg)
                IDLE:    if (ss_ev) state_next = RUN;
                RUN:     if (zero) state_next = EXPIRED;
                         else if (ss_ev) state_next = PAUSE;
                PAUSE:   if (ss_ev) state_next = RUN;
                EXPIRED: state_next = EXPIRED;
                default: state_next = IDLE;
            endcase
        end
    end

    // Suppressing cnt_en on clear keeps it disjoint from cnt_load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_en_reg     <= 1'b0;
            cnt_load_reg   <= 1'b1;
            lap_active_reg <= 1'b0;
            hold_reg       <= '0;
        end else begin
            cnt_en_reg   <= tick & ~zero & ~clr_ev;
            cnt_load_reg <= clr_ev;
            if (clr_ev || exp_entry) begin
                lap_active_reg <= 1'b0;
            end else if (lap_take) begin
                lap_active_reg <= ~lap_active_reg;
            end
            if (lap_take && !lap_active_reg) begin
                hold_reg <= live;
            end
        end
    end

    always_comb begin
        disp_sel       = lap_active_reg ? hold_reg : live;
        bus.cnt_en     = cnt_en_reg;
        bus.cnt_load   = cnt_load_reg;
        bus.lap_active = lap_active_reg;
        bus.running    = (state_reg == RUN);
        bus.paused     = (state_reg == PAUSE);
        bus.expired    = (state_reg == EXPIRED);
        bus.disp_m2    = disp_sel.m2;
        bus.disp_m1    = disp_sel.m1;
        bus.disp_s2    = disp_sel.s2;
        bus.disp_s1    = disp_sel.s1;
    end

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Bench for stop_watch_ctrl: a seconds-based countdown model stands in for the
// datapath, and a mode/phase model of the controller is compared every cycle.
module tb_stop_watch_ctrl;
    import sw_pkg::*;

    localparam int DIV     = 4;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_EXP   = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    stop_watch_ctrl_if sw_bus();

    stop_watch_ctrl #(
        .TICK_DIV (DIV),
        .PS_W     (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sw_bus)
    );

    always #5 clk = ~clk;

    int n_cmp    = 0;
    int n_bad    = 0;
    int en_count = 0;

    // Datapath model state: remaining time in seconds (3599 = 59:59).
    int secs    = 3599;
    int pre_val = 0;
    int pre_req = 0;
    int pre_ack = 0;

    // Controller model state.
    bit started = 1'b0;
    int m_mode  = S_IDLE;
    int m_ps    = 0;
    int m_hold  = 0;
    bit m_en    = 1'b0;
    bit m_load  = 1'b1;
    bit m_lap   = 1'b0;
    bit p_ss    = 1'b0;
    bit p_lap   = 1'b0;
    bit p_clr   = 1'b0;

    function automatic logic [13:0] dig(input int t);
        int m;
        int s;
        m = t / 60;
        s = t % 60;
        return {4'(m % 10), 3'(m / 10), 4'(s % 10), 3'(s / 10)};
    endfunction

    function automatic logic [13:0] pk(input int m2, input int m1, input int s2, input int s1);
        return {4'(m2), 3'(m1), 4'(s2), 3'(s1)};
    endfunction

    function automatic logic [13:0] disp_now();
        return {sw_bus.disp_m2, sw_bus.disp_m1, sw_bus.disp_s2, sw_bus.disp_s1};
    endfunction

    logic [13:0] dp_d;
    assign dp_d          = dig(secs);
    assign sw_bus.cnt_m2 = dp_d[13:10];
    assign sw_bus.cnt_m1 = dp_d[9:7];
    assign sw_bus.cnt_s2 = dp_d[6:3];
    assign sw_bus.cnt_s1 = dp_d[2:0];

    task automatic cmp(input string name, input logic [13:0] got, input logic [13:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic lit(input string name, input logic [13:0] got, input logic [13:0] exp);
        $display("step %s: %0h (expected %0h) at %0t", name, got, exp, $time);
        cmp(name, got, exp);
    endtask

    always @(posedge clk) begin : model
        bit ss;
        bit lp;
        bit cl;
        bit zero;
        bit tick;
        if (pre_req != pre_ack) begin
            secs    <= pre_val;
            pre_ack <= pre_req;
        end else if (sw_bus.cnt_load === 1'b1) begin
            secs <= 3599;
        end else if (sw_bus.cnt_en === 1'b1 && secs > 0) begin
            secs <= secs - 1;
        end
        started <= 1'b1;

        if (!reset) begin
            m_mode = S_IDLE;
            m_ps   = 0;
            m_en   = 1'b0;
            m_load = 1'b1;
            m_lap  = 1'b0;
            m_hold = 0;
            p_ss   = 1'b0;
            p_lap  = 1'b0;
            p_clr  = 1'b0;
        end else begin
            ss    = sw_bus.start_stop && !p_ss;
            lp    = sw_bus.lap && !p_lap;
            cl    = sw_bus.clear && !p_clr;
            p_ss  = sw_bus.start_stop;
            p_lap = sw_bus.lap;
            p_clr = sw_bus.clear;
            zero  = (secs == 0);
            tick  = (m_mode == S_RUN) && (m_ps == DIV - 1);
            m_en   = tick && !zero && !cl;
            m_load = cl;
            if (cl) begin
                m_mode = S_IDLE;
                m_ps   = 0;
                m_lap  = 1'b0;
            end else begin
                case (m_mode)
                    S_IDLE: if (ss) m_mode = S_RUN;
                    S_RUN: begin
                        if (zero) begin
                            m_mode = S_EXP;
                            m_ps   = 0;
                            m_lap  = 1'b0;
                        end else begin
                            m_ps = (m_ps + 1) % DIV;
                            if (ss) m_mode = S_PAUSE;
                            else if (lp) begin
                                if (!m_lap) m_hold = secs;
                                m_lap = !m_lap;
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (ss) m_mode = S_RUN;
                        else if (lp) begin
                            if (!m_lap) m_hold = secs;
                            m_lap = !m_lap;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            cmp("ctrl", {8'b0, sw_bus.cnt_en, sw_bus.cnt_load, sw_bus.running,
                         sw_bus.paused, sw_bus.expired, sw_bus.lap_active},
                        {8'b0, m_en, m_load, m_mode == S_RUN, m_mode == S_PAUSE,
                         m_mode == S_EXP, m_lap});
            cmp("disp", disp_now(), m_lap ? dig(m_hold) : dig(secs));
            cmp("en_load_excl", 14'(sw_bus.cnt_en & sw_bus.cnt_load), 14'd0);
            if (sw_bus.cnt_en === 1'b1) en_count++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       sw_bus.start_stop = v;
            1:       sw_bus.lap        = v;
            default: sw_bus.clear      = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        cyc(1);
        set_btn(b, 1'b0);
    endtask

    task automatic preload(input int v);
        pre_val = v;
        pre_req++;
        cyc(1);
    endtask

    task automatic wait_en(input int target, input int budget);
        for (int i = 0; i < budget && en_count < target; i++) cyc(1);
        lit("wait_cnt_en", 14'(en_count >= target), 14'd1);
    endtask

    initial begin : stim
        int base;
        int n;
        sw_bus.start_stop = 1'b0;
        sw_bus.lap        = 1'b0;
        sw_bus.clear      = 1'b0;

        // Reset and release
        cyc(3);
        lit("load_in_reset", 14'(sw_bus.cnt_load), 14'd1);
        lit("en_in_reset", 14'(sw_bus.cnt_en), 14'd0);
        reset = 1'b1;
        cyc(1);
        lit("load_drop", 14'(sw_bus.cnt_load), 14'd0);
        lit("idle_not_running", 14'(sw_bus.running), 14'd0);
        lit("disp_preset", disp_now(), pk(PRESET_M2, PRESET_M1, PRESET_S2, PRESET_S1));

        // Run three seconds, pause mid-second, resume
        base = en_count;
        press(0);
        lit("running", 14'(sw_bus.running), 14'd1);
        wait_en(base + 3, 40);
        cyc(1);
        lit("disp_59_56", disp_now(), pk(9, 5, 6, 5));
        press(0);
        lit("paused", 14'(sw_bus.paused), 14'd1);
        base = en_count;
        cyc(20);
        lit("no_en_in_pause", 14'(en_count), 14'(base));
        sw_bus.start_stop = 1'b1;
        cyc(1);
        sw_bus.start_stop = 1'b0;
        n = 1;
        while (en_count == base && n < 20) begin
            cyc(1);
            n++;
        end
        lit("resume_latency", 14'(n), 14'd3);

        // Countdown from 00:02 to expiry
        press(2);
        cyc(2);
        preload(2);
        lit("disp_00_02", disp_now(), pk(0, 0, 2, 0));
        base = en_count;
        press(0);
        wait_en(base + 2, 40);
        cyc(1);
        lit("not_yet_expired", 14'(sw_bus.expired), 14'd0);
        cyc(1);
        lit("expired", 14'(sw_bus.expired), 14'd1);
        lit("disp_00_00", disp_now(), pk(0, 0, 0, 0));
        cyc(10);
        lit("no_third_pulse", 14'(en_count), 14'(base + 2));
        press(0);
        press(1);
        lit("expired_sticky", 14'(sw_bus.expired), 14'd1);
        press(2);
        lit("clear_load", 14'(sw_bus.cnt_load), 14'd1);
        lit("clear_exits_expired", 14'(sw_bus.expired), 14'd0);
        cyc(1);
        lit("disp_after_clear", disp_now(), pk(9, 5, 9, 5));

        // Lap hold at 59:50
        cyc(1);
        preload(3590);
        base = en_count;
        press(0);
        press(1);
        lit("lap_on", 14'(sw_bus.lap_active), 14'd1);
        lit("lap_disp", disp_now(), pk(9, 5, 0, 5));
        wait_en(base + 3, 40);
        cyc(1);
        lit("lap_frozen", disp_now(), pk(9, 5, 0, 5));
        press(1);
        lit("lap_off", 14'(sw_bus.lap_active), 14'd0);
        lit("live_59_47", disp_now(), pk(9, 5, 7, 4));
        press(2);
        cyc(1);
        press(1);
        lit("lap_idle_ignored", 14'(sw_bus.lap_active), 14'd0);

        // Clear beats start_stop, held button, reset mid-run
        press(0);
        cyc(2);
        sw_bus.start_stop = 1'b1;
        sw_bus.clear      = 1'b1;
        cyc(1);
        sw_bus.start_stop = 1'b0;
        sw_bus.clear      = 1'b0;
        lit("clr_ss_load", 14'(sw_bus.cnt_load), 14'd1);
        lit("clr_ss_no_en", 14'(sw_bus.cnt_en), 14'd0);
        lit("clr_ss_idle", 14'(sw_bus.running), 14'd0);
        cyc(2);
        sw_bus.start_stop = 1'b1;
        cyc(10);
        lit("held_single_edge", 14'(sw_bus.running), 14'd1);
        sw_bus.start_stop = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        lit("rst_load", 14'(sw_bus.cnt_load), 14'd1);
        lit("rst_state", 14'({sw_bus.cnt_en, sw_bus.running, sw_bus.lap_active}), 14'd0);
        reset = 1'b1;
        cyc(2);

        // Randomized button activity with occasional preloads and resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0)  sw_bus.start_stop = ~sw_bus.start_stop;
            if ($urandom_range(0, 9) == 0)  sw_bus.lap        = ~sw_bus.lap;
            if ($urandom_range(0, 49) == 0) sw_bus.clear      = ~sw_bus.clear;
            if ($urandom_range(0, 79) == 0) begin
                pre_val = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3599))
                                                      : int'($urandom_range(0, 6));
                pre_req++;
            end
            reset = ($urandom_range(0, 399) != 0);
            cyc(1);
        end
        reset = 1'b1;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stop_watch_ctrl.md
Name: stop_watch_ctrl

Overview:
Run/pause/lap/clear controller for the mm:ss countdown datapath (`stop_watch`, 59:59 → 00:00). It converts debounced button levels into sequencing commands for that datapath:
- a 1 Hz count-enable from a prescaler;
- a preset/load strobe;
- expiry detection at 00:00;
- a lap-hold display mux.

It sits between the button debouncers and the datapath/display driver.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per count tick (1 s); legal range ≥ 4.
- PS_W, 26, prescaler width; must hold TICK_DIV-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start_stop  in  1  debounced start/pause button level.
- lap  in  1  debounced lap button level.
- clear  in  1  debounced clear button level.
- cnt_m2  in  4  datapath minutes-ones digit (0-9).
- cnt_m1  in  3  datapath minutes-tens digit (0-5).
- cnt_s2  in  4  datapath seconds-ones digit (0-9).
- cnt_s1  in  3  datapath seconds-tens digit (0-5).
- cnt_en  out  1  one-cycle decrement strobe to datapath.
- cnt_load  out  1  active-high preset strobe; drives datapath sync reset (→ 59:59).
- disp_m2/disp_m1/disp_s2/disp_s1  out  4/3/4/3  digits to display (live or lap-held).
- running  out  1  state == RUN.
- paused  out  1  state == PAUSE.
- expired  out  1  state == EXPIRED.
- lap_active  out  1  display frozen on lap capture.

Behaviour:
- All outputs registered. While reset is low:
  - state = IDLE, prescaler = 0, edge-detect registers = 0;
  - cnt_en = 0, cnt_load = 1, lap_active = 0, hold registers = 0;
  - disp_* = live cnt_*.
- cnt_load drops on the first cycle after reset goes high.
- Buttons: rising-edge detect (prev-level register); a level held high produces one event only.
- Same-cycle event priority: clear > start_stop > lap.
- zero = all cnt_* == 0, taken combinationally from the inputs.
- Prescaler:
  - counts 0..TICK_DIV-1 only in RUN, wraps to 0;
  - holds its value in PAUSE, so a resumed second keeps its partial progress;
  - cleared by reset, clear, and entry to EXPIRED.
- tick = RUN && prescaler == TICK_DIV-1.
- cnt_en = registered (tick && !zero): a 1-cycle pulse in the cycle after the terminal count, exactly one per TICK_DIV cycles.
- FSM:
  - IDLE: start_stop → RUN.
  - RUN: zero → EXPIRED (highest priority, even over a same-cycle start_stop); start_stop → PAUSE.
  - PAUSE: start_stop → RUN.
  - EXPIRED: start_stop and lap ignored.
  - Any state: clear → IDLE, with cnt_load = 1 for exactly 1 cycle, prescaler = 0, lap_active = 0.
- IDLE is exited only by start_stop. No auto-start after clear.
- Expiry latency: datapath reaches 00:00 on the cnt_en edge; zero is seen the next cycle; expired = 1 one cycle later. No further cnt_en, so the datapath never wraps to 59:59.
- Lap:
  - lap event in RUN or PAUSE toggles lap_active;
  - on 0→1, cnt_* are captured into hold registers in the same edge;
  - disp_* = hold when lap_active, else live cnt_*;
  - counting continues underneath;
  - lap in IDLE is ignored;
  - entry to EXPIRED forces lap_active = 0, so the display shows 00:00.
- Clear mid-RUN: the datapath presets the next edge and any pending cnt_en is suppressed. cnt_en and cnt_load are never high in the same cycle.

Decomposition:
- sw_pkg:
  - state enum {IDLE, RUN, PAUSE, EXPIRED};
  - digit widths MIN_ONES_W=4, MIN_TENS_W=3, SEC_ONES_W=4, SEC_TENS_W=3;
  - preset constants 5/9/5/9.
- Sub-module sw_prescaler (params TICK_DIV, PS_W):
  - inputs clk, reset, run, clr;
  - output tick.
- FSM, edge detect and lap mux stay in the top module.

Test Plan (TICK_DIV=4; bench runs a behavioural `stop_watch` model on cnt_en/cnt_load):
- Reset low 3 cycles, then release → cnt_load=1 during reset and 0 the cycle after; state IDLE; display 59:59; cnt_en never asserted.
- start_stop edge → running=1; cnt_en pulses every 4 cycles; after 3 pulses display 59:56. Pause after 2 prescaler counts, hold 20 cycles → no cnt_en; resume → next cnt_en after 2 more counts.
- Preload model to 00:02, run → 2 cnt_en pulses, display 00:00, expired=1 two cycles after the last pulse, no third pulse. start_stop/lap then ignored; clear → IDLE, 59:59.
- RUN at 59:50, lap edge → lap_active=1, disp frozen at 59:50 while the model reaches 59:47. Second lap → live 59:47. Lap in IDLE → no change.
- Same-cycle clear+start_stop in RUN → IDLE, one cnt_load pulse, no cnt_en that cycle. start_stop held high 10 cycles → a single transition. Reset asserted mid-RUN → all outputs at reset values on the next edge.
